inst_encoder: RTL and testbench

INST_ENCODER -- requirements
Module: inst_encoder

---
 rtl/inst_encoder_if.sv | 29 ++
 rtl/inst_encoder.sv | 159 +++++++++++++++
 tb/tb_inst_encoder.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_encoder_if.sv
// Request and instruction-memory write bundle for inst_encoder.
// The master drives requests and memory acceptance; the slave (the encoder) answers.
interface inst_encoder_if;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_mn;
  logic [4:0]  req_rs;
  logic [4:0]  req_rt;
  logic [4:0]  req_rd;
  logic [4:0]  req_shamt;
  logic [15:0] req_imm;
  logic [25:0] req_target;
  logic        imem_we;
  logic        imem_ready;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;

  modport master (
    output req_valid, req_mn, req_rs, req_rt, req_rd, req_shamt, req_imm, req_target,
    output imem_ready,
    input  req_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  req_valid, req_mn, req_rs, req_rt, req_rd, req_shamt, req_imm, req_target,
    input  imem_ready,
    output req_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/inst_encoder.sv
// Encodes mnemonic requests into MIPS words, buffers them in a 4-deep FIFO and streams them to imem.
// Optional macro ILLEGAL_CHK_EN: drop illegal mnemonics and raise the sticky err flag.
module inst_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        addr_load,
  input  logic [31:0] addr_base,
  input  logic        err_clr,
  output logic [2:0]  fill,
  output logic        err,
  inst_encoder_if.slave bus
);

  typedef enum logic [5:0] {
    MN_ADD   = 6'd0,  MN_ADDU  = 6'd1,  MN_SUB   = 6'd2,  MN_SUBU  = 6'd3,
    MN_AND   = 6'd4,  MN_OR    = 6'd5,  MN_XOR   = 6'd6,  MN_NOR   = 6'd7,
    MN_SLT   = 6'd8,  MN_SLTU  = 6'd9,  MN_SLL   = 6'd10, MN_SRL   = 6'd11,
    MN_SRA   = 6'd12, MN_SLLV  = 6'd13, MN_SRLV  = 6'd14, MN_SRAV  = 6'd15,
    MN_JR    = 6'd16, MN_JALR  = 6'd17, MN_ADDI  = 6'd18, MN_ADDIU = 6'd19,
    MN_ANDI  = 6'd20, MN_ORI   = 6'd21, MN_XORI  = 6'd22, MN_SLTI  = 6'd23,
    MN_SLTIU = 6'd24, MN_LUI   = 6'd25, MN_LW    = 6'd26, MN_SW    = 6'd27,
    MN_LB    = 6'd28, MN_LBU   = 6'd29, MN_SB    = 6'd30, MN_BEQ   = 6'd31,
    MN_BNE   = 6'd32, MN_BGTZ  = 6'd33, MN_BLEZ  = 6'd34, MN_BGEZ  = 6'd35,
    MN_BLTZ  = 6'd36, MN_J     = 6'd37, MN_JAL   = 6'd38, MN_HALT  = 6'd39
  } mn_e;

  function automatic logic [31:0] r_word(input logic [5:0] funct, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] rd,
                                         input logic [4:0] shamt);
    return {6'b000000, rs, rt, rd, shamt, funct};
  endfunction

  function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  logic [4:0]  rs, rt, rd, sh;
  logic [15:0] imm;
  logic [31:0] enc_word;
  logic        enc_illegal;

  assign rs  = bus.req_rs;
  assign rt  = bus.req_rt;
  assign rd  = bus.req_rd;
  assign sh  = bus.req_shamt;
  assign imm = bus.req_imm;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    enc_word    = '0;
    enc_illegal = 1'b0;
    case (bus.req_mn)
      MN_ADD:   enc_word = r_word(6'b100000, rs, rt, rd, 5'd0);
      MN_ADDU:  enc_word = r_word(6'b100001, rs, rt, rd, 5'd0);
      MN_SUB:   enc_word = r_word(6'b100010, rs, rt, rd, 5'd0);
      MN_SUBU:  enc_word = r_word(6'b100011, rs, rt, rd, 5'd0);
      MN_AND:   enc_word = r_word(6'b100100, rs, rt, rd, 5'd0);
      MN_OR:    enc_word = r_word(6'b100101, rs, rt, rd, 5'd0);
      MN_XOR:   enc_word = r_word(6'b100110, rs, rt, rd, 5'd0);
      MN_NOR:   enc_word = r_word(6'b100111, rs, rt, rd, 5'd0);
      MN_SLT:   enc_word = r_word(6'b101010, rs, rt, rd, 5'd0);
      MN_SLTU:  enc_word = r_word(6'b101011, rs, rt, rd, 5'd0);
      MN_SLL:   enc_word = r_word(6'b000000, 5'd0, rt, rd, sh);
      MN_SRL:   enc_word = r_word(6'b000010, 5'd0, rt, rd, sh);
      MN_SRA:   enc_word = r_word(6'b000011, 5'd0, rt, rd, sh);
      MN_SLLV:  enc_word = r_word(6'b000100, rs, rt, rd, 5'd0);
      MN_SRLV:  enc_word = r_word(6'b000110, rs, rt, rd, 5'd0);
      MN_SRAV:  enc_word = r_word(6'b000111, rs, rt, rd, 5'd0);
      MN_JR:    enc_word = r_word(6'b001000, rs, 5'd0, 5'd0, 5'd0);
      MN_JALR:  enc_word = r_word(6'b001001, rs, 5'd0, rd, 5'd0);
      MN_ADDI:  enc_word = i_word(6'b001000, rs, rt, imm);
      MN_ADDIU: enc_word = i_word(6'b001001, rs, rt, imm);
      MN_ANDI:  enc_word = i_word(6'b001100, rs, rt, imm);
      MN_ORI:   enc_word = i_word(6'b001101, rs, rt, imm);
      MN_XORI:  enc_word = i_word(6'b001110, rs, rt, imm);
      MN_SLTI:  enc_word = i_word(6'b001010, rs, rt, imm);
      MN_SLTIU: enc_word = i_word(6'b001011, rs, rt, imm);
      MN_LUI:   enc_word = i_word(6'b001111, 5'd0, rt, imm);
      MN_LW:    enc_word = i_word(6'b100011, rs, rt, imm);
      MN_SW:    enc_word = i_word(6'b101011, rs, rt, imm);
      MN_LB:    enc_word = i_word(6'b100000, rs, rt, imm);
      MN_LBU:   enc_word = i_word(6'b100100, rs, rt, imm);
      MN_SB:    enc_word = i_word(6'b101000, rs, rt, imm);
      MN_BEQ:   enc_word = i_word(6'b000100, rs, rt, imm);
      MN_BNE:   enc_word = i_word(6'b000101, rs, rt, imm);
      MN_BGTZ:  enc_word = i_word(6'b000111, rs, 5'd0, imm);
      MN_BLEZ:  enc_word = i_word(6'b000110, rs, 5'd0, imm);
      MN_BGEZ:  enc_word = i_word(6'b000001, rs, 5'd1, imm);
      MN_BLTZ:  enc_word = i_word(6'b000001, rs, 5'd0, imm);
      MN_J:     enc_word = {6'b000010, bus.req_target};
      MN_JAL:   enc_word = {6'b000011, bus.req_target};
      MN_HALT:  enc_word = 32'hFC00_0000;
      default:  enc_illegal = 1'b1;
    endcase
  end

  logic [31:0] mem [4];
  logic [1:0]  wr_idx, rd_idx;
  logic [2:0]  count;
  logic [31:0] ptr;
  logic        accept, push, pop;

  assign bus.req_ready  = (count != 3'd4);
  assign bus.imem_we    = (count != 3'd0);
  assign bus.imem_wdata = bus.imem_we ? mem[rd_idx] : 32'h0;
  assign bus.imem_addr  = ptr;
  assign fill           = count;

  assign accept = bus.req_valid & bus.req_ready;
  assign pop    = bus.imem_we & bus.imem_ready;
`ifdef ILLEGAL_CHK_EN
  assign push   = accept & ~enc_illegal;
`else
  assign push   = accept;
`endif

  // NOTE: storage is not reset; the gated imem_wdata mux keeps stale entries invisible after rst.
  always_ff @(posedge clk) begin
    if (push) mem[wr_idx] <= enc_word;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_idx <= '0;
      rd_idx <= '0;
      count  <= '0;
      ptr    <= '0;
    end else begin
      if (push) wr_idx <= wr_idx + 2'd1;
      if (pop)  rd_idx <= rd_idx + 2'd1;
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
      // A reload wins over the post-write increment.
      if (addr_load)  ptr <= {addr_base[31:2], 2'b00};
      else if (pop)   ptr <= ptr + 32'd4;
    end
  end

`ifdef ILLEGAL_CHK_EN
  logic err_q;
  always_ff @(posedge clk) begin
    if (rst)                        err_q <= 1'b0;
    else if (accept && enc_illegal) err_q <= 1'b1;
    else if (err_clr)               err_q <= 1'b0;
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  logic unused_bits;
  assign unused_bits = ^{err_clr, addr_base[1:0], enc_illegal};

endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: encoding vectors, FIFO/pointer corner sequences and
// a randomized run scored against a queue-based reference model.
module tb_inst_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        addr_load;
  logic [31:0] addr_base;
  logic        err_clr;
  logic [2:0]  fill;
  logic        err;

  inst_encoder_if bus ();

  inst_encoder dut (
    .clk       (clk),
    .rst       (rst),
    .addr_load (addr_load),
    .addr_base (addr_base),
    .err_clr   (err_clr),
    .fill      (fill),
    .err       (err),
    .bus       (bus.slave)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoder built from the opcode/funct tables.
  int unsigned r_funct [18] = '{32, 33, 34, 35, 36, 37, 38, 39, 42, 43, 0, 2, 3, 4, 6, 7, 8, 9};
  int unsigned i_op    [19] = '{8, 9, 12, 13, 14, 10, 11, 15, 35, 43, 32, 36, 40, 4, 5, 7, 6, 1, 1};

  function automatic logic [31:0] ref_enc(int unsigned mn, int unsigned rs, int unsigned rt,
                                          int unsigned rd, int unsigned sh, int unsigned imm,
                                          int unsigned tgt);
    logic [31:0] w;
    if (mn < 18) begin
      if (mn >= 10 && mn <= 12) rs = 0; else sh = 0;
      if (mn == 16) begin rt = 0; rd = 0; end
      if (mn == 17) rt = 0;
      w = rs * 2097152 + rt * 65536 + rd * 2048 + sh * 64 + r_funct[mn];
    end else if (mn < 37) begin
      if (mn == 25) rs = 0;
      if (mn == 33 || mn == 34 || mn == 36) rt = 0;
      if (mn == 35) rt = 1;
      w = i_op[mn-18] * 67108864 + rs * 2097152 + rt * 65536 + imm;
    end else if (mn == 37) w = 2 * 67108864 + tgt;
    else if (mn == 38)     w = 3 * 67108864 + tgt;
    else if (mn == 39)     w = 32'hFC00_0000;
    else                   w = 32'h0;
    return w;
  endfunction

  logic [31:0] mq [$];
  logic [31:0] m_addr;
  logic        m_err;

  // Compare all outputs against the model mid-cycle, then advance the model across the edge.
  task automatic cycle();
    logic [31:0] w;
    logic [31:0] head;
    bit acc, pp, ill;
    @(negedge clk);
    head = (mq.size() != 0) ? mq[0] : 32'h0;
    check("fill", {29'd0, fill}, mq.size());
    check("req_ready", {31'd0, bus.req_ready}, {31'd0, mq.size() != 4});
    check("imem_we", {31'd0, bus.imem_we}, {31'd0, mq.size() != 0});
    check("imem_wdata", bus.imem_wdata, head);
    check("imem_addr", bus.imem_addr, m_addr);
    check("err", {31'd0, err}, {31'd0, m_err});
    if (rst) begin
      mq.delete();
      m_addr = 0;
      m_err  = 0;
    end else begin
      acc = bus.req_valid && mq.size() < 4;
      pp  = mq.size() > 0 && bus.imem_ready;
      ill = bus.req_mn >= 40;
      w   = ref_enc(bus.req_mn, bus.req_rs, bus.req_rt, bus.req_rd, bus.req_shamt,
                    bus.req_imm, bus.req_target);
      if (pp) void'(mq.pop_front());
`ifdef ILLEGAL_CHK_EN
      if (acc && !ill) mq.push_back(w);
      if (acc && ill) m_err = 1;
      else if (err_clr) m_err = 0;
`else
      if (acc) mq.push_back(w);
`endif
      if (addr_load) m_addr = addr_base & 32'hFFFF_FFFC;
      else if (pp)   m_addr = m_addr + 32'd4;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic req(input int unsigned mn, input int unsigned rs, input int unsigned rt,
                     input int unsigned rd, input int unsigned sh, input int unsigned imm,
                     input int unsigned tgt);
    bus.req_valid  = 1'b1;
    bus.req_mn     = 6'(mn);
    bus.req_rs     = 5'(rs);
    bus.req_rt     = 5'(rt);
    bus.req_rd     = 5'(rd);
    bus.req_shamt  = 5'(sh);
    bus.req_imm    = 16'(imm);
    bus.req_target = 26'(tgt);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  task automatic load(input logic [31:0] base);
    addr_load = 1'b1;
    addr_base = base;
    cycle();
    addr_load = 1'b0;
  endtask

  typedef struct {
    int unsigned mn, rs, rt, rd, sh, imm, tgt;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [11];

  logic [31:0] burst_words [4] = '{32'h0800_0100, 32'h0C00_0040, 32'hFC00_0000, 32'h0022_1820};

  initial begin
    vecs[0]  = '{0, 1, 2, 3, 0, 0, 0, 32'h0022_1820};       // add
    vecs[1]  = '{10, 7, 1, 2, 4, 0, 0, 32'h0001_1100};      // sll, rs forced 0
    vecs[2]  = '{18, 1, 2, 0, 0, 16'hFFFF, 0, 32'h2022_FFFF}; // addi
    vecs[3]  = '{36, 4, 9, 0, 0, 3, 0, 32'h0480_0003};      // bltz, rt forced 0
    vecs[4]  = '{37, 0, 0, 0, 0, 0, 32'h100, 32'h0800_0100}; // j
    vecs[5]  = '{38, 0, 0, 0, 0, 0, 32'h40, 32'h0C00_0040};  // jal
    vecs[6]  = '{39, 5, 5, 5, 5, 5, 5, 32'hFC00_0000};      // halt
    vecs[7]  = '{16, 31, 5, 6, 3, 0, 0, 32'h03E0_0008};     // jr
    vecs[8]  = '{25, 3, 4, 0, 0, 16'h1234, 0, 32'h3C04_1234}; // lui, rs forced 0
    vecs[9]  = '{35, 2, 7, 0, 0, 16'h10, 0, 32'h0441_0010}; // bgez, rt forced 1
    vecs[10] = '{0, 1, 2, 3, 9, 0, 0, 32'h0022_1820};       // add, shamt forced 0

    rst = 1'b1; addr_load = 1'b0; addr_base = '0; err_clr = 1'b0;
    bus.req_valid = 1'b0; bus.imem_ready = 1'b0;
    req(0, 0, 0, 0, 0, 0, 0);
    bus.req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    mq.delete(); m_addr = 0; m_err = 0;
    rst = 1'b0;
    check("reset fill", {29'd0, fill}, 32'd0);
    check("reset req_ready", {31'd0, bus.req_ready}, 32'd1);
    check("reset imem_addr", bus.imem_addr, 32'd0);

    // Single add, one-cycle latency to imem_we, then the encoding table.
    load(32'h1000);
    bus.imem_ready = 1'b1;
    req(0, 1, 2, 3, 0, 0, 0);
    cycle();
    bus.req_valid = 1'b0;
    check("latency imem_we", {31'd0, bus.imem_we}, 32'd1);
    check("latency wdata", bus.imem_wdata, 32'h0022_1820);
    check("latency addr", bus.imem_addr, 32'h1000);
    foreach (vecs[i]) begin
      req(vecs[i].mn, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].sh, vecs[i].imm, vecs[i].tgt);
      cycle();
      bus.req_valid = 1'b0;
      check($sformatf("vec%0d word", i), bus.imem_wdata, vecs[i].exp);
    end
    repeat (2) cycle();

    // Fill to full with imem stalled, then drain in order.
    do_reset();
    load(32'h1000);
    bus.imem_ready = 1'b0;
    req(37, 0, 0, 0, 0, 0, 32'h100); cycle();
    req(38, 0, 0, 0, 0, 0, 32'h40);  cycle();
    req(39, 0, 0, 0, 0, 0, 0);       cycle();
    bus.req_valid = 1'b0;
    check("fill3", {29'd0, fill}, 32'd3);
    check("fill3 req_ready", {31'd0, bus.req_ready}, 32'd1);
    req(0, 1, 2, 3, 0, 0, 0); cycle();
    check("fill4", {29'd0, fill}, 32'd4);
    check("fill4 req_ready", {31'd0, bus.req_ready}, 32'd0);
    req(39, 0, 0, 0, 0, 0, 0); cycle();
    bus.req_valid = 1'b0;
    check("full no push", {29'd0, fill}, 32'd4);
    bus.imem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain%0d wdata", i), bus.imem_wdata, burst_words[i]);
      check($sformatf("drain%0d addr", i), bus.imem_addr, 32'h1000 + 32'(4 * i));
      cycle();
    end
    check("drained", {29'd0, fill}, 32'd0);

    // Illegal mnemonic and err_clr interplay.
    do_reset();
    bus.imem_ready = 1'b0;
    req(45, 1, 1, 1, 1, 1, 1); cycle();
    bus.req_valid = 1'b0;
`ifdef ILLEGAL_CHK_EN
    check("illegal err", {31'd0, err}, 32'd1);
    check("illegal no push", {29'd0, fill}, 32'd0);
    req(45, 0, 0, 0, 0, 0, 0);
    err_clr = 1'b1;
    cycle();
    bus.req_valid = 1'b0;
    check("clr+illegal err", {31'd0, err}, 32'd1);
`else
    check("illegal pushed", {29'd0, fill}, 32'd1);
    check("illegal word", bus.imem_wdata, 32'h0);
    err_clr = 1'b1;
`endif
    cycle();
    err_clr = 1'b0;
    check("err cleared", {31'd0, err}, 32'd0);

    // Pointer wrap and load-over-increment priority.
    do_reset();
    load(32'hFFFF_FFFC);
    bus.imem_ready = 1'b1;
    req(1, 1, 1, 1, 0, 0, 0); cycle();
    bus.req_valid = 1'b0;
    cycle();
    check("addr wrap", bus.imem_addr, 32'h0);
    req(2, 1, 1, 1, 0, 0, 0); cycle();
    bus.req_valid = 1'b0;
    addr_load = 1'b1; addr_base = 32'h2003;
    cycle();
    addr_load = 1'b0;
    check("load priority", bus.imem_addr, 32'h2000);

    // Reset mid-stream overrides every concurrent request.
    bus.imem_ready = 1'b0;
    req(37, 0, 0, 0, 0, 0, 1); cycle();
    req(38, 0, 0, 0, 0, 0, 2); cycle();
    req(39, 0, 0, 0, 0, 0, 0); cycle();
    check("pre-reset fill", {29'd0, fill}, 32'd3);
    rst = 1'b1; addr_load = 1'b1; addr_base = 32'h4000; bus.imem_ready = 1'b1;
    cycle();
    rst = 1'b0; addr_load = 1'b0; bus.req_valid = 1'b0;
    check("rst fill", {29'd0, fill}, 32'd0);
    check("rst imem_we", {31'd0, bus.imem_we}, 32'd0);
    check("rst addr", bus.imem_addr, 32'd0);
    check("rst wdata", bus.imem_wdata, 32'd0);

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      req($urandom_range(0, 45), $urandom_range(0, 31), $urandom_range(0, 31),
          $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 65535), $urandom);
      bus.req_valid  = ($urandom_range(0, 2) != 0);
      bus.imem_ready = ($urandom_range(0, 2) == 0);
      addr_load      = ($urandom_range(0, 19) == 0);
      addr_base      = $urandom;
      err_clr        = ($urandom_range(0, 9) == 0);
      rst            = ($urandom_range(0, 99) == 0);
      cycle();
    end
    rst = 1'b0; bus.req_valid = 1'b0; addr_load = 1'b0; err_clr = 1'b0;
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
